// File: rtl/semaforo_temporizador_if.sv
// -----------------------------------------------------------------------------
// semaforo_temporizador_if
//
// Groups the control inputs and the status outputs of the phase timer.
//
//   enable       : timer runs while high, freezes while low
//   limpa        : synchronous realign to phase 00
//   req_pedestre : pedestrian request (level or pulse)
//   pulso        : one-cycle end-of-phase pulse towards the controller
//   fase         : mirror of the controller's 2-bit phase
//   restante     : ticks left in the current phase
//   pendente     : pedestrian request latched and not yet served
//
// The master side drives the controls; the slave side is the timer itself.
// -----------------------------------------------------------------------------
interface semaforo_temporizador_if #(
  parameter int WIDTH = 8
) ();

  logic             enable;
  logic             limpa;
  logic             req_pedestre;
  logic             pulso;
  logic [1:0]       fase;
  logic [WIDTH-1:0] restante;
  logic             pendente;

  modport master (
    output enable, limpa, req_pedestre,
    input  pulso, fase, restante, pendente
  );

  modport slave (
    input  enable, limpa, req_pedestre,
    output pulso, fase, restante, pendente
  );

endinterface

// File: rtl/semaforo_temporizador.sv
// -----------------------------------------------------------------------------
// semaforo_temporizador
//
// Phase timer for the two-street traffic-light controller. A prescaler divides
// the clock into ticks; each light phase lasts a programmable number of ticks
// and ends with a one-cycle pulse on bus.pulso that advances the controller.
// A local copy of the controller's phase selects green or yellow duration, and
// a latched pedestrian request cuts the remaining green time short.
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of semaforo_temporizador_if
//           (enable, limpa, req_pedestre in; pulso, fase, restante, pendente out)
// -----------------------------------------------------------------------------
module semaforo_temporizador #(
  parameter int PRESC       = 1000,
  parameter int WIDTH       = 8,
  parameter int T_VERDE     = 30,
  parameter int T_AMARELO   = 5,
  parameter int T_MIN_VERDE = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  semaforo_temporizador_if.slave  bus
);

  // Prescaler needs at least one bit even when every edge is a tick.
  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;

  localparam logic [PW-1:0]    PRESC_MAX   = PW'(PRESC - 1);
  localparam logic [WIDTH-1:0] T_VERDE_W   = WIDTH'(T_VERDE);
  localparam logic [WIDTH-1:0] T_AMARELO_W = WIDTH'(T_AMARELO);
  localparam logic [WIDTH-1:0] T_MIN_W     = WIDTH'(T_MIN_VERDE);

  // Phase encoding matches the controller: bit 0 set means yellow.
  typedef enum logic [1:0] {
    FASE_R2_VERDE   = 2'b00,
    FASE_R2_AMARELO = 2'b01,
    FASE_R1_VERDE   = 2'b10,
    FASE_R1_AMARELO = 2'b11
  } fase_t;

  fase_t            fase_q,     fase_d;
  logic [PW-1:0]    presc_q,    presc_d;
  logic [WIDTH-1:0] restante_q, restante_d;
  logic             pulso_q,    pulso_d;
  logic             pendente_q, pendente_d;
  logic             tick;

  // Duration of a phase in ticks: yellow phases are the odd codes.
  function automatic logic [WIDTH-1:0] duracao(input fase_t f);
    return f[0] ? T_AMARELO_W : T_VERDE_W;
  endfunction

  // Next-state logic. The tick outcome is decided first; the pedestrian set
  // is applied last so a request arriving on the edge that ends a green phase
  // survives the clear of the request being served.
  always_comb begin
    fase_d     = fase_q;
    presc_d    = presc_q;
    restante_d = restante_q;
    pendente_d = pendente_q;
    pulso_d    = 1'b0;
    tick       = 1'b0;

    if (bus.limpa) begin
      fase_d     = FASE_R2_VERDE;
      presc_d    = '0;
      restante_d = T_VERDE_W;
      pendente_d = 1'b0;
    end else begin
      if (bus.enable) begin
        if (presc_q == PRESC_MAX) begin
          presc_d = '0;
          tick    = 1'b1;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end

      if (tick) begin
        if (restante_q == WIDTH'(1)) begin
          pulso_d    = 1'b1;
          fase_d     = fase_t'(fase_q + 2'd1);
          restante_d = duracao(fase_t'(fase_q + 2'd1));
          if (!fase_q[0]) begin
            pendente_d = 1'b0;
          end
        end else if (!fase_q[0] && pendente_q && (restante_q > T_MIN_W)) begin
          restante_d = T_MIN_W;
        end else begin
          restante_d = restante_q - WIDTH'(1);
        end
      end

      if (bus.req_pedestre) begin
        pendente_d = 1'b1;
      end
    end
  end

  // State register; reset puts the timer at the start of rua 2 green.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fase_q     <= FASE_R2_VERDE;
      presc_q    <= '0;
      restante_q <= T_VERDE_W;
      pulso_q    <= 1'b0;
      pendente_q <= 1'b0;
    end else begin
      fase_q     <= fase_d;
      presc_q    <= presc_d;
      restante_q <= restante_d;
      pulso_q    <= pulso_d;
      pendente_q <= pendente_d;
    end
  end

  assign bus.pulso    = pulso_q;
  assign bus.fase     = fase_q;
  assign bus.restante = restante_q;
  assign bus.pendente = pendente_q;

endmodule

// File: tb/tb_semaforo_temporizador.sv
// -----------------------------------------------------------------------------
// tb_semaforo_temporizador
//
// Directed bench for the phase timer with PRESC=4, T_VERDE=6, T_AMARELO=2,
// T_MIN_VERDE=2. Edge numbers count rising edges after reset release, the
// first being edge 1; outputs are sampled 1 ns after each edge.
// -----------------------------------------------------------------------------
module tb_semaforo_temporizador;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;
  int   edge_n;

  semaforo_temporizador_if #(.WIDTH(8)) bus ();

  semaforo_temporizador #(
    .PRESC      (4),
    .WIDTH      (8),
    .T_VERDE    (6),
    .T_AMARELO  (2),
    .T_MIN_VERDE(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hold reset for a few edges, then release between edges so the next
  // rising edge is edge 1.
  task automatic reset_dut();
    rst_n            = 1'b0;
    bus.enable       = 1'b1;
    bus.limpa        = 1'b0;
    bus.req_pedestre = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    edge_n = 0;
  endtask

  // Advance one rising edge and sample shortly after it.
  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic test_reset();
    rst_n            = 1'b0;
    bus.enable       = 1'b1;
    bus.limpa        = 1'b0;
    bus.req_pedestre = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.pulso !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset pulso: got %0b expected 0", bus.pulso);
    end
    tests_run++;
    if (bus.fase !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL reset fase: got %b expected 00", bus.fase);
    end
    tests_run++;
    if (bus.restante !== 8'd6) begin
      tests_failed++;
      $display("[TB] FAIL reset restante: got %0d expected 6", bus.restante);
    end
    tests_run++;
    if (bus.pendente !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset pendente: got %0b expected 0", bus.pendente);
    end
  endtask

  task automatic test_free_run();
    int          pulse_edges [5] = '{24, 32, 56, 64, 88};
    logic [1:0]  pulse_fases [5] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
    int          k;
    logic        exp_p;
    logic [7:0]  exp_r;
    reset_dut();
    k = 0;
    for (int e = 1; e <= 90; e++) begin
      step();
      exp_p = (k < 5) && (edge_n == pulse_edges[k]);
      tests_run++;
      if (bus.pulso !== exp_p) begin
        tests_failed++;
        $display("[TB] FAIL free_run pulso edge %0d: got %0b expected %0b", edge_n, bus.pulso, exp_p);
      end
      if (exp_p) begin
        tests_run++;
        if (bus.fase !== pulse_fases[k]) begin
          tests_failed++;
          $display("[TB] FAIL free_run fase edge %0d: got %b expected %b", edge_n, bus.fase, pulse_fases[k]);
        end
        k++;
      end
      if (edge_n < 24) begin
        exp_r = 8'(6 - edge_n / 4);
        tests_run++;
        if (bus.restante !== exp_r) begin
          tests_failed++;
          $display("[TB] FAIL free_run restante edge %0d: got %0d expected %0d", edge_n, bus.restante, exp_r);
        end
      end
    end
  endtask

  task automatic test_pause();
    logic exp_p;
    reset_dut();
    repeat (4) step();
    bus.enable = 1'b0;
    for (int e = 5; e <= 14; e++) begin
      step();
      tests_run++;
      if (bus.restante !== 8'd5 || bus.pulso !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL pause frozen edge %0d: got restante %0d pulso %0b expected 5 0", edge_n, bus.restante, bus.pulso);
      end
    end
    bus.enable = 1'b1;
    for (int e = 15; e <= 34; e++) begin
      step();
      exp_p = (edge_n == 34);
      tests_run++;
      if (bus.pulso !== exp_p) begin
        tests_failed++;
        $display("[TB] FAIL pause pulso edge %0d: got %0b expected %0b", edge_n, bus.pulso, exp_p);
      end
    end
    tests_run++;
    if (bus.fase !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL pause fase: got %b expected 01", bus.fase);
    end
  endtask

  task automatic test_pedestre_verde();
    logic exp_p;
    reset_dut();
    step();
    tests_run++;
    if (bus.pendente !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL ped_green pendente edge 1: got %0b expected 0", bus.pendente);
    end
    bus.req_pedestre = 1'b1;
    step();
    bus.req_pedestre = 1'b0;
    tests_run++;
    if (bus.pendente !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL ped_green pendente edge 2: got %0b expected 1", bus.pendente);
    end
    for (int e = 3; e <= 12; e++) begin
      step();
      exp_p = (edge_n == 12);
      tests_run++;
      if (bus.pulso !== exp_p) begin
        tests_failed++;
        $display("[TB] FAIL ped_green pulso edge %0d: got %0b expected %0b", edge_n, bus.pulso, exp_p);
      end
      if (edge_n == 4) begin
        tests_run++;
        if (bus.restante !== 8'd2) begin
          tests_failed++;
          $display("[TB] FAIL ped_green restante edge 4: got %0d expected 2", bus.restante);
        end
      end
      if (edge_n == 8) begin
        tests_run++;
        if (bus.restante !== 8'd1) begin
          tests_failed++;
          $display("[TB] FAIL ped_green restante edge 8: got %0d expected 1", bus.restante);
        end
      end
    end
    tests_run++;
    if (bus.fase !== 2'b01 || bus.pendente !== 1'b0 || bus.restante !== 8'd2) begin
      tests_failed++;
      $display("[TB] FAIL ped_green end edge 12: got fase %b pendente %0b restante %0d expected 01 0 2", bus.fase, bus.pendente, bus.restante);
    end
  endtask

  task automatic test_pedestre_amarelo();
    logic exp_p;
    reset_dut();
    repeat (25) step();
    bus.req_pedestre = 1'b1;
    step();
    bus.req_pedestre = 1'b0;
    for (int e = 27; e <= 44; e++) begin
      step();
      exp_p = (edge_n == 32) || (edge_n == 44);
      tests_run++;
      if (bus.pulso !== exp_p) begin
        tests_failed++;
        $display("[TB] FAIL ped_yellow pulso edge %0d: got %0b expected %0b", edge_n, bus.pulso, exp_p);
      end
      if (edge_n == 32) begin
        tests_run++;
        if (bus.pendente !== 1'b1 || bus.fase !== 2'b10) begin
          tests_failed++;
          $display("[TB] FAIL ped_yellow edge 32: got pendente %0b fase %b expected 1 10", bus.pendente, bus.fase);
        end
      end
      if (edge_n == 36) begin
        tests_run++;
        if (bus.restante !== 8'd2) begin
          tests_failed++;
          $display("[TB] FAIL ped_yellow restante edge 36: got %0d expected 2", bus.restante);
        end
      end
    end
    tests_run++;
    if (bus.fase !== 2'b11 || bus.pendente !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL ped_yellow end edge 44: got fase %b pendente %0b expected 11 0", bus.fase, bus.pendente);
    end
  endtask

  task automatic test_limpa();
    logic exp_p;
    reset_dut();
    repeat (39) step();
    bus.limpa        = 1'b1;
    bus.req_pedestre = 1'b1;
    step();
    bus.limpa        = 1'b0;
    bus.req_pedestre = 1'b0;
    tests_run++;
    if (bus.fase !== 2'b00 || bus.restante !== 8'd6 || bus.pendente !== 1'b0 || bus.pulso !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL limpa state: got fase %b restante %0d pendente %0b pulso %0b expected 00 6 0 0",
               bus.fase, bus.restante, bus.pendente, bus.pulso);
    end
    for (int e = 41; e <= 64; e++) begin
      step();
      exp_p = (edge_n == 64);
      tests_run++;
      if (bus.pulso !== exp_p) begin
        tests_failed++;
        $display("[TB] FAIL limpa pulso edge %0d: got %0b expected %0b", edge_n, bus.pulso, exp_p);
      end
    end
  endtask

  task automatic test_async_reset();
    reset_dut();
    repeat (30) step();
    bus.req_pedestre = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.fase !== 2'b00 || bus.restante !== 8'd6 || bus.pendente !== 1'b0 || bus.pulso !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset immediate: got fase %b restante %0d pendente %0b pulso %0b expected 00 6 0 0",
               bus.fase, bus.restante, bus.pendente, bus.pulso);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.pendente !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset held pendente: got %0b expected 0", bus.pendente);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    edge_n = 0;
    step();
    bus.req_pedestre = 1'b0;
    tests_run++;
    if (bus.pendente !== 1'b1 || bus.restante !== 8'd6 || bus.pulso !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset edge 1: got pendente %0b restante %0d pulso %0b expected 1 6 0",
               bus.pendente, bus.restante, bus.pulso);
    end
    repeat (3) step();
    tests_run++;
    if (bus.restante !== 8'd2) begin
      tests_failed++;
      $display("[TB] FAIL async_reset restante edge 4: got %0d expected 2", bus.restante);
    end
  endtask

  initial begin
    tests_run        = 0;
    tests_failed     = 0;
    edge_n           = 0;
    rst_n            = 1'b0;
    bus.enable       = 1'b0;
    bus.limpa        = 1'b0;
    bus.req_pedestre = 1'b0;
    test_reset();
    test_free_run();
    test_pause();
    test_pedestre_verde();
    test_pedestre_amarelo();
    test_limpa();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
